// File: rtl/axi4_burst_tester.sv
// AXI4 full master that writes a counting pattern in INCR bursts, reads it back
// and counts mismatches, bad responses and misplaced RLAST beats.
module axi4_burst_tester #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_BURST_LEN        = 8,
    parameter int C_NUM_BURSTS       = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASE = '0
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [7:0]                      err_cnt,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [3:0]                      M_AXI_AWQOS,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]                      M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARLOCK,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic [3:0]                      M_AXI_ARQOS,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [7:0]    LAST_BEAT  = 8'(C_BURST_LEN - 1);
    localparam logic [4:0]    LAST_BURST = 5'(C_NUM_BURSTS - 1);
    localparam logic [DW-1:0] ONE_D      = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_t;

    function automatic logic [AW-1:0] burst_addr(input logic [4:0] b);
        return C_TARGET_BASE + AW'(b) * AW'(C_BURST_LEN * 4);
    endfunction

    // Beat k of burst b carries b*BURST_LEN + k + 1 (wraps at the data width).
    function automatic logic [DW-1:0] beat_data(input logic [4:0] b, input logic [7:0] k);
        return DW'(b) * DW'(C_BURST_LEN) + DW'(k) + ONE_D;
    endfunction

    state_t        state_q, state_d;
    logic [4:0]    burst_q, burst_d;
    logic [7:0]    beat_q, beat_d;
    logic          awvalid_q, awvalid_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic          wvalid_q, wvalid_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wlast_q, wlast_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic [AW-1:0] araddr_q, araddr_d;
    logic          rready_q, rready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic       bresp_bad, rdata_bad, rresp_bad, rlast_bad;
    logic [1:0] r_err_inc, err_inc;
    logic [8:0] err_sum;
    logic [7:0] err_sat;
    logic       unused_ok;

    assign aw_hs = awvalid_q & M_AXI_AWREADY;
    assign w_hs  = wvalid_q  & M_AXI_WREADY;
    assign b_hs  = bready_q  & M_AXI_BVALID;
    assign ar_hs = arvalid_q & M_AXI_ARREADY;
    assign r_hs  = rready_q  & M_AXI_RVALID;

    assign bresp_bad = (M_AXI_BRESP != 2'b00);
    assign rdata_bad = (M_AXI_RDATA != beat_data(burst_q, beat_q));
    assign rresp_bad = (M_AXI_RRESP != 2'b00);
    assign rlast_bad = (M_AXI_RLAST != (beat_q == LAST_BEAT));
    assign r_err_inc = 2'(rdata_bad) + 2'(rresp_bad) + 2'(rlast_bad);

    // B and R handshakes never coincide, so at most one source contributes.
    assign err_inc = (b_hs ? 2'(bresp_bad) : 2'd0) + (r_hs ? r_err_inc : 2'd0);
    assign err_sum = {1'b0, err_cnt_q} + 9'(err_inc);
    assign err_sat = err_sum[8] ? 8'hFF : err_sum[7:0];

    assign unused_ok = ^{M_AXI_BID, M_AXI_RID};

    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        wvalid_d  = wvalid_q;
        wdata_d   = wdata_q;
        wlast_d   = wlast_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        rready_d  = rready_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_AW;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_cnt_d = 8'd0;
                    burst_d   = 5'd0;
                    awvalid_d = 1'b1;
                    awaddr_d  = burst_addr(5'd0);
                end
            end
            S_AW: begin
                if (aw_hs) begin
                    state_d   = S_W;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    beat_d    = 8'd0;
                    wdata_d   = beat_data(burst_q, 8'd0);
                    wlast_d   = (LAST_BEAT == 8'd0);
                end
            end
            S_W: begin
                if (w_hs) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d  = S_B;
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        wdata_d = wdata_q + ONE_D;
                        wlast_d = ((beat_q + 8'd1) == LAST_BEAT);
                    end
                end
            end
            S_B: begin
                if (b_hs) begin
                    bready_d  = 1'b0;
                    err_cnt_d = err_sat;
                    if (burst_q != LAST_BURST) begin
                        state_d   = S_AW;
                        burst_d   = burst_q + 5'd1;
                        awvalid_d = 1'b1;
                        awaddr_d  = burst_addr(burst_q + 5'd1);
                    end else begin
                        state_d   = S_AR;
                        burst_d   = 5'd0;
                        arvalid_d = 1'b1;
                        araddr_d  = burst_addr(5'd0);
                    end
                end
            end
            S_AR: begin
                if (ar_hs) begin
                    state_d   = S_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    beat_d    = 8'd0;
                end
            end
            S_R: begin
                if (r_hs) begin
                    err_cnt_d = err_sat;
                    // The beat count alone ends the burst; RLAST is only checked.
                    if (beat_q == LAST_BEAT) begin
                        rready_d = 1'b0;
                        if (burst_q != LAST_BURST) begin
                            state_d   = S_AR;
                            burst_d   = burst_q + 5'd1;
                            arvalid_d = 1'b1;
                            araddr_d  = burst_addr(burst_q + 5'd1);
                        end else begin
                            state_d = S_DONE;
                            burst_d = 5'd0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (err_sat == 8'd0);
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            burst_q   <= '0;
            beat_q    <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_cnt_q;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = LAST_BEAT;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'd0;
    assign M_AXI_AWPROT  = 3'd0;
    assign M_AXI_AWQOS   = 4'd0;
    assign M_AXI_AWVALID = awvalid_q;

    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = 4'hF;
    assign M_AXI_WLAST  = wlast_q;
    assign M_AXI_WVALID = wvalid_q;

    assign M_AXI_BREADY = bready_q;

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = LAST_BEAT;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'd0;
    assign M_AXI_ARPROT  = 3'd0;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARVALID = arvalid_q;

    assign M_AXI_RREADY = rready_q;

endmodule
